// File: rtl/gt_common_pkg.sv
// Shared definitions for the GT common PLL reset supervisor: per-PLL FSM
// state encoding and the PLL index assignments.
package gt_common_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_RESET     = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_STABLE    = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;
    localparam logic [2:0] ST_FAIL      = 3'd5;

    typedef enum logic [2:0] {
        OFF       = ST_OFF,
        RESET     = ST_RESET,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        READY     = ST_READY,
        FAIL      = ST_FAIL
    } pll_state_t;

    localparam int PLL_PCIE = 0;
    localparam int PLL_SFP  = 1;

endpackage

// File: rtl/gt_pll_rst_fsm.sv
// Bring-up supervisor for one GTPE2 PLL: input synchronizers, sequencing FSM,
// reset/lock timers, retry bookkeeping and a saturating relock counter.
module gt_pll_rst_fsm
    import gt_common_pkg::*;
#(
    parameter int RST_CYCLES   = 32,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             lock_async,
    input  logic             refclk_lost_async,
    output logic             pd,
    output logic             reset,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] relock_cnt
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int NW = $clog2(MAX_RETRY + 1);

    localparam logic [RW-1:0] RST_LOAD  = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
    localparam logic [NW-1:0] RETRY_MAX = NW'(MAX_RETRY);

    logic lock_p0, lock_s;
    logic lost_p0, lost_s;

    pll_state_t       state, state_nx;
    logic [RW-1:0]    rst_cnt, rst_cnt_nx;
    logic [TW-1:0]    tmo_cnt, tmo_cnt_nx;
    logic [SW-1:0]    stb_cnt, stb_cnt_nx;
    logic [NW-1:0]    retry, retry_nx, retry_inc;
    logic [CNT_W-1:0] relock_nx;

    // Stage p0 -> s: two-flop synchronizers for the wrapper's async status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
            lost_p0 <= 1'b0;
            lost_s  <= 1'b0;
        end else begin
            lock_p0 <= lock_async;
            lock_s  <= lock_p0;
            lost_p0 <= refclk_lost_async;
            lost_s  <= lost_p0;
        end
    end

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        tmo_cnt_nx = tmo_cnt;
        stb_cnt_nx = stb_cnt;
        retry_nx   = retry;
        relock_nx  = relock_cnt;
        retry_inc  = retry + 1'b1;

        if (!en) begin
            state_nx = OFF;
            retry_nx = '0;
        end else if (restart && state != OFF) begin
            state_nx   = RESET;
            rst_cnt_nx = RST_LOAD;
            retry_nx   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nx   = RESET;
                    rst_cnt_nx = RST_LOAD;
                end
                RESET: begin
                    if (lost_s) begin
                        rst_cnt_nx = RST_LOAD;
                    end else if (rst_cnt == '0) begin
                        state_nx   = WAIT_LOCK;
                        tmo_cnt_nx = '0;
                    end else begin
                        rst_cnt_nx = rst_cnt - 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle takes precedence
                    if (lock_s) begin
                        state_nx   = STABLE;
                        stb_cnt_nx = '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        retry_nx = retry_inc;
                        if (retry_inc == RETRY_MAX) begin
                            state_nx = FAIL;
                        end else begin
                            state_nx   = RESET;
                            rst_cnt_nx = RST_LOAD;
                        end
                    end else begin
                        tmo_cnt_nx = tmo_cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nx   = WAIT_LOCK;
                        tmo_cnt_nx = '0;
                    end else if (lost_s) begin
                        state_nx   = RESET;
                        rst_cnt_nx = RST_LOAD;
                    end else if (stb_cnt == STB_LAST) begin
                        state_nx = READY;
                        retry_nx = '0;
                    end else begin
                        stb_cnt_nx = stb_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (!lock_s || lost_s) begin
                        state_nx   = RESET;
                        rst_cnt_nx = RST_LOAD;
                        if (relock_cnt != '1) begin
                            relock_nx = relock_cnt + 1'b1;
                        end
                    end
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = OFF;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            rst_cnt    <= '0;
            tmo_cnt    <= '0;
            stb_cnt    <= '0;
            retry      <= '0;
            relock_cnt <= '0;
            pd         <= 1'b1;
            reset      <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nx;
            rst_cnt    <= rst_cnt_nx;
            tmo_cnt    <= tmo_cnt_nx;
            stb_cnt    <= stb_cnt_nx;
            retry      <= retry_nx;
            relock_cnt <= relock_nx;
            pd         <= (state_nx == OFF) || (state_nx == FAIL);
            reset      <= (state_nx == OFF) || (state_nx == RESET) || (state_nx == FAIL);
            ready      <= (state_nx == READY);
            fail       <= (state_nx == FAIL);
        end
    end

endmodule

// File: rtl/gt_common_pll_rst_ctrl.sv
// Power-up/reset/lock supervisor for both GTPE2 common PLLs (PLL0 = PCIe,
// PLL1 = SFP); each PLL runs its own independent sequencer.
module gt_common_pll_rst_ctrl
    import gt_common_pkg::*;
#(
    parameter int RST_CYCLES   = 32,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pll_en,
    input  logic [1:0]       restart,
    input  logic [1:0]       pll_lock_async,
    input  logic [1:0]       refclk_lost_async,
    output logic [1:0]       pll_pd,
    output logic [1:0]       pll_reset,
    output logic [1:0]       pll_ready,
    output logic [1:0]       pll_fail,
    output logic [CNT_W-1:0] relock_cnt0,
    output logic [CNT_W-1:0] relock_cnt1
);

    gt_pll_rst_fsm #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY),
        .CNT_W       (CNT_W)
    ) u_pll_pcie (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (pll_en[PLL_PCIE]),
        .restart          (restart[PLL_PCIE]),
        .lock_async       (pll_lock_async[PLL_PCIE]),
        .refclk_lost_async(refclk_lost_async[PLL_PCIE]),
        .pd               (pll_pd[PLL_PCIE]),
        .reset            (pll_reset[PLL_PCIE]),
        .ready            (pll_ready[PLL_PCIE]),
        .fail             (pll_fail[PLL_PCIE]),
        .relock_cnt       (relock_cnt0)
    );

    gt_pll_rst_fsm #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY),
        .CNT_W       (CNT_W)
    ) u_pll_sfp (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (pll_en[PLL_SFP]),
        .restart          (restart[PLL_SFP]),
        .lock_async       (pll_lock_async[PLL_SFP]),
        .refclk_lost_async(refclk_lost_async[PLL_SFP]),
        .pd               (pll_pd[PLL_SFP]),
        .reset            (pll_reset[PLL_SFP]),
        .ready            (pll_ready[PLL_SFP]),
        .fail             (pll_fail[PLL_SFP]),
        .relock_cnt       (relock_cnt1)
    );

endmodule

// File: tb/tb_gt_common_pll_rst_ctrl.sv
// Directed bench for gt_common_pll_rst_ctrl with small timing parameters.
module tb_gt_common_pll_rst_ctrl;

    localparam int CNT_W = 8;

    // Per-PLL observable code {fail, ready, reset, pd}
    localparam logic [3:0] C_OFF  = 4'b0011;
    localparam logic [3:0] C_RST  = 4'b0010;
    localparam logic [3:0] C_RUN  = 4'b0000;
    localparam logic [3:0] C_RDY  = 4'b0100;
    localparam logic [3:0] C_FAIL = 4'b1011;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       pll_en = '0;
    logic [1:0]       restart = '0;
    logic [1:0]       lock = '0;
    logic [1:0]       lost = '0;
    logic [1:0]       pll_pd, pll_reset, pll_ready, pll_fail;
    logic [CNT_W-1:0] relock_cnt0, relock_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    gt_common_pll_rst_ctrl #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(20),
        .LOCK_STABLE (8),
        .MAX_RETRY   (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_en           (pll_en),
        .restart          (restart),
        .pll_lock_async   (lock),
        .refclk_lost_async(lost),
        .pll_pd           (pll_pd),
        .pll_reset        (pll_reset),
        .pll_ready        (pll_ready),
        .pll_fail         (pll_fail),
        .relock_cnt0      (relock_cnt0),
        .relock_cnt1      (relock_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic [1:0] lk;
        int         cyc;
        logic [1:0] pd;
        logic [1:0] rs;
        logic [1:0] rdy;
        logic [1:0] fl;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [3:0] st(input int i);
        return {pll_fail[i], pll_ready[i], pll_reset[i], pll_pd[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ticks until PLL i shows code; n = ticks taken
    task automatic wait_code(input int i, input logic [3:0] code, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (st(i) != code && n < bound);
        if (st(i) != code) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_code pll%0d: code %b after %0d cycles, wanted %b", i, st(i), n, code);
        end
    endtask

    // Length in cycles of the current run of code on PLL i (current cycle included)
    task automatic run_len(input int i, input logic [3:0] code, input int bound, output int n);
        n = 1;
        tick();
        while (st(i) == code && n < bound) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        pll_en  = '0;
        restart = '0;
        lock    = '0;
        lost    = '0;
        repeat (2) tick();
        check("reset pd", pll_pd, 2'b11);
        check("reset rst", pll_reset, 2'b11);
        check("reset rdy", pll_ready, 2'b00);
        check("reset fail", pll_fail, 2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tot, bad;

        // Nominal bring-up of PLL0, then disable, then enable PLL1 without lock
        vecs[0] = '{2'b00, 2'b00, 1,  2'b11, 2'b11, 2'b00, 2'b00};
        vecs[1] = '{2'b01, 2'b00, 1,  2'b10, 2'b11, 2'b00, 2'b00};
        vecs[2] = '{2'b01, 2'b00, 3,  2'b10, 2'b11, 2'b00, 2'b00};
        vecs[3] = '{2'b01, 2'b00, 1,  2'b10, 2'b10, 2'b00, 2'b00};
        vecs[4] = '{2'b01, 2'b00, 5,  2'b10, 2'b10, 2'b00, 2'b00};
        vecs[5] = '{2'b01, 2'b01, 10, 2'b10, 2'b10, 2'b00, 2'b00};
        vecs[6] = '{2'b01, 2'b01, 1,  2'b10, 2'b10, 2'b01, 2'b00};
        vecs[7] = '{2'b00, 2'b01, 1,  2'b11, 2'b11, 2'b00, 2'b00};
        vecs[8] = '{2'b10, 2'b01, 1,  2'b01, 2'b11, 2'b00, 2'b00};

        do_reset();
        for (int v = 0; v < 9; v++) begin
            pll_en = vecs[v].en;
            lock   = vecs[v].lk;
            repeat (vecs[v].cyc) tick();
            check($sformatf("vec%0d pd", v), pll_pd, vecs[v].pd);
            check($sformatf("vec%0d reset", v), pll_reset, vecs[v].rs);
            check($sformatf("vec%0d ready", v), pll_ready, vecs[v].rdy);
            check($sformatf("vec%0d fail", v), pll_fail, vecs[v].fl);
        end

        // Restart in RESET reloads; lock never arrives -> two windows then FAIL
        do_reset();
        pll_en = 2'b01;
        tick();
        check("t2 enter reset", st(0), C_RST);
        tick();
        restart = 2'b01;
        tick();
        restart = 2'b00;
        run_len(0, C_RST, 50, n);
        check("t2 reset after restart", n, 4);
        run_len(0, C_RUN, 50, n);
        check("t2 wait window 1", n, 20);
        run_len(0, C_RST, 50, n);
        check("t2 retry reset len", n, 4);
        run_len(0, C_RUN, 50, n);
        check("t2 wait window 2", n, 20);
        check("t2 fail state", st(0), C_FAIL);
        check("t2 pll1 off", st(1), C_OFF);
        repeat (5) tick();
        check("t2 fail held", st(0), C_FAIL);
        restart = 2'b01;
        tick();
        restart = 2'b00;
        check("t2 restart from fail", st(0), C_RST);
        run_len(0, C_RST, 50, n);
        check("t2 reset len after fail", n, 4);
        run_len(0, C_RUN, 50, n);
        check("t2 wait after restart", n, 20);
        check("t2 retry cleared", st(0), C_RST);

        // Single-cycle lock drop in READY, then saturation of relock counter
        do_reset();
        pll_en = 2'b11;
        lock   = 2'b11;
        wait_code(0, C_RDY, 100, n);
        check("t3 both ready", pll_ready, 2'b11);
        lock = 2'b10;
        tick();
        check("t3 ready k+1", pll_ready[0], 1'b1);
        lock = 2'b11;
        tick();
        check("t3 ready k+2", pll_ready[0], 1'b1);
        tick();
        check("t3 ready drop k+3", st(0), C_RST);
        run_len(0, C_RST, 50, n);
        check("t3 reseq reset len", n, 4);
        run_len(0, C_RUN, 50, n);
        check("t3 reseq lock+stable len", n, 9);
        check("t3 ready again", st(0), C_RDY);
        check("t3 relock0 one", relock_cnt0, 1);
        for (int k = 1; k < 300; k++) begin
            lock = 2'b10;
            tick();
            lock = 2'b11;
            wait_code(0, C_RST, 10, n);
            wait_code(0, C_RDY, 40, n);
            if (k == 254) check("t3 relock0 255", relock_cnt0, 255);
        end
        check("t3 relock0 saturated", relock_cnt0, 255);
        check("t3 relock1 untouched", relock_cnt1, 0);
        check("t3 pll1 still ready", st(1), C_RDY);

        // refclk lost held in RESET
        do_reset();
        lost = 2'b01;
        repeat (3) tick();
        pll_en = 2'b01;
        tick();
        check("t4 enter reset", st(0), C_RST);
        bad = 0;
        repeat (50) begin
            tick();
            if (st(0) != C_RST) bad++;
        end
        check("t4 reset held cycles", bad, 0);
        lost = 2'b00;
        run_len(0, C_RST, 50, n);
        check("t4 reset tail len", n, 6);
        check("t4 wait_lock entered", st(0), C_RUN);

        // Lock glitch at STABLE cycle 5 forces a fresh stable window
        do_reset();
        pll_en = 2'b01;
        wait_code(0, C_RUN, 20, n);
        lock = 2'b01;
        repeat (5) tick();
        lock = 2'b00;
        tick();
        lock = 2'b01;
        wait_code(0, C_RDY, 60, n);
        tot = 6 + n;
        check("t5 ready after glitch", tot, 17);

        // Lock arriving on the timeout cycle wins
        do_reset();
        pll_en = 2'b01;
        wait_code(0, C_RUN, 20, n);
        repeat (17) tick();
        lock = 2'b01;
        wait_code(0, C_RDY, 60, n);
        check("t7 lock beats timeout", n, 11);
        check("t7 relock0 zero", relock_cnt0, 0);

        // pll_en drop in READY and async reset mid-STABLE
        do_reset();
        pll_en = 2'b11;
        lock   = 2'b11;
        wait_code(0, C_RDY, 100, n);
        check("t6 pll1 ready", st(1), C_RDY);
        pll_en = 2'b01;
        tick();
        check("t6 pll1 off", st(1), C_OFF);
        check("t6 pll0 unaffected", st(0), C_RDY);
        check("t6 relock1 zero", relock_cnt1, 0);
        pll_en = 2'b11;
        tick();
        check("t6 pll1 reset", st(1), C_RST);
        wait_code(1, C_RUN, 20, n);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t6 async pd", pll_pd, 2'b11);
        check("t6 async reset", pll_reset, 2'b11);
        check("t6 async ready", pll_ready, 2'b00);
        check("t6 async fail", pll_fail, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gt_common_pll_rst_ctrl.md
Name: gt_common_pll_rst_ctrl

Overview:
Power-up, reset and lock supervisor for the two PLLs of the GTPE2 common block (PLL0 = PCIe, PLL1 = SFP). It drives the PLLxPD and PLLxRESET inputs of the GT common wrapper. It consumes that wrapper's PLLxLOCK and PLLxREFCLKLOST outputs and re-sequences a PLL on timeout or loss of lock. The `clk` input also drives PLL0LOCKDETCLK and PLL1LOCKDETCLK at top level. Downstream consumers (PCIe core, SFP transceiver reset logic) gate on `pll_ready`.

Parameters:
- RST_CYCLES, 32: clk cycles PLLxRESET is held after PD release (minimum 1).
- LOCK_TIMEOUT, 65536: clk cycles allowed in WAIT_LOCK before a retry.
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before `pll_ready` asserts.
- MAX_RETRY, 4: consecutive timeouts before entering FAIL.
- CNT_W, 8: width of the saturating relock counters.

Ports:
- clk  in  1  free-running system clock; also used as the lock-detect clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_en  in  2  per-PLL enable; bit0 = PLL0, bit1 = PLL1.
- restart  in  2  per-PLL single-cycle restart request.
- pll_lock_async  in  2  PLLxLOCK from the GT common wrapper; asynchronous.
- refclk_lost_async  in  2  PLLxREFCLKLOST from the GT common wrapper; asynchronous.
- pll_pd  out  2  to PLLxPD.
- pll_reset  out  2  to PLLxRESET.
- pll_ready  out  2  PLL locked and stable.
- pll_fail  out  2  retries exhausted.
- relock_cnt0  out  CNT_W  loss-of-lock events on PLL0, saturating.
- relock_cnt1  out  CNT_W  loss-of-lock events on PLL1, saturating.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous, active-low, with synchronous deassertion handled externally.
- Under reset: pll_pd=2'b11, pll_reset=2'b11, pll_ready=0, pll_fail=0, relock counters=0, every FSM in OFF, retry counts=0.
- Each asynchronous input passes through a 2-FF synchronizer (`*_s` below). An input edge is visible to the FSM 2 cycles later.
- Each PLL has an independent FSM. All outputs are registered Moore decodes of the state register.
- OFF: pd=1, reset=1. Go to RESET when pll_en=1.
- RESET: pd=0, reset=1. Down-counter loaded with RST_CYCLES-1 on entry.
  - The counter reloads every cycle while refclk_lost_s=1.
  - Go to WAIT_LOCK when the counter reaches 0 and refclk_lost_s=0.
- WAIT_LOCK: pd=0, reset=0. Timer counts from 0 on entry.
  - lock_s=1 → STABLE.
  - Timer reaches LOCK_TIMEOUT-1 → retry count +1. If the new value equals MAX_RETRY, go to FAIL; otherwise go to RESET.
- STABLE: counter counts consecutive lock_s=1 cycles.
  - lock_s=0 → WAIT_LOCK, with the timer restarted.
  - refclk_lost_s=1 → RESET.
  - LOCK_STABLE cycles reached → READY, retry count cleared.
- READY: pll_ready=1.
  - lock_s=0 or refclk_lost_s=1 → RESET, relock count +1, saturating at all-ones.
- FAIL: pd=1, reset=1, pll_fail=1. Exit only via restart → RESET, or pll_en=0 → OFF.
- Priority, highest first: rst_n, then pll_en=0 (→ OFF from any state, next cycle), then restart (→ RESET from any non-OFF state, retry count cleared), then the state transitions above.
  - restart is ignored in OFF.
  - restart while in RESET reloads the counter.
- Simultaneous events:
  - Timeout on the same cycle as lock_s=1: lock wins (→ STABLE).
  - lock loss on the same cycle as refclk loss in READY: a single relock increment.
- Retry count width is clog2(MAX_RETRY+1). Timers are sized from clog2 of their parameter.
- The two FSMs never interact. Simultaneous events on both PLLs are handled independently in the same cycle.

Decomposition:
- Package gt_common_pkg: enum pll_state_t {OFF, RESET, WAIT_LOCK, STABLE, READY, FAIL}, and the PLL index constants PLL_PCIE=0 and PLL_SFP=1.
- Sub-module gt_pll_rst_fsm: one PLL's synchronizers, FSM, timers, retry count and relock counter. The top instantiates it twice and maps the counters to relock_cnt0 and relock_cnt1.

Test Plan:
All tests use RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
1. Nominal bring-up: pll_en[0] rises, lock_async[0] rises 10 cycles later → pd[0] falls 1 cycle after en_s. reset[0] high exactly 4 cycles. pll_ready[0] high 2+8+1 cycles after lock rises. PLL1 outputs unchanged.
2. Lock never arrives → two WAIT_LOCK windows of 20 cycles, each followed by a 4-cycle RESET pulse. Then FAIL with pd=1, reset=1, pll_fail=1. A restart pulse returns to RESET with pll_fail=0.
3. Lock drops during READY for 1 cycle → pll_ready falls 3 cycles later, a full re-sequence runs, and relock_cnt increments to 1. Repeat 300 times → relock_cnt saturates at 255.
4. refclk_lost held high during RESET for 50 cycles → reset stays high throughout, then WAIT_LOCK starts 4 cycles after refclk_lost_s falls.
5. Lock glitches low at STABLE cycle 5 → return to WAIT_LOCK with no READY. A fresh 8-cycle window is required.
6. rst_n asserted mid-STABLE, and pll_en dropped in READY → outputs reach reset values immediately (async) or the OFF state the next cycle, respectively. The other PLL is unaffected.
